// File: rtl/native_arbiter_if.sv
// rtl/native_arbiter_if.sv - flattened native-bus bundle of N_PORTS lanes with master/slave views
interface native_arbiter_if #(
    parameter int N_PORTS = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [N_PORTS-1:0]          valid;
    logic [N_PORTS*ADDR_W-1:0]   addr;
    logic [N_PORTS*DATA_W-1:0]   wdata;
    logic [N_PORTS*DATA_W/8-1:0] wstrb;
    logic [N_PORTS*DATA_W-1:0]   rdata;
    logic [N_PORTS-1:0]          ready;

    modport master (output valid, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/native_arbiter.sv
// rtl/native_arbiter.sv - round-robin arbiter sharing one native-bus slave among N masters, with watchdog
module native_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    native_arbiter_if.slave  m_bus,
    native_arbiter_if.master s_bus,
    output logic             timeout_err,
    output logic [2:0]       err_master
);
    localparam int IDX_W  = $clog2(N_MASTERS);
    localparam int STRB_W = DATA_W / 8;
    localparam bit WD_EN  = (TIMEOUT > 0);
    localparam int WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   grant, grant_n, last, last_n;
    logic [WD_W-1:0]    wd_cnt, wd_n;
    logic               terr_n;
    logic [2:0]         emst_n;

    logic [IDX_W-1:0]   pick, cand;
    logic               any_req;
    logic               s_valid, ret_ready;
    logic [DATA_W-1:0]  ret_data;

    logic [ADDR_W-1:0]  addr_a  [N_MASTERS];
    logic [DATA_W-1:0]  wdata_a [N_MASTERS];
    logic [STRB_W-1:0]  wstrb_a [N_MASTERS];

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
        assign addr_a[i]  = m_bus.addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = m_bus.wdata[i*DATA_W +: DATA_W];
        assign wstrb_a[i] = m_bus.wstrb[i*STRB_W +: STRB_W];
        assign m_bus.ready[i] = ret_ready && (grant == IDX_W'(i));
        assign m_bus.rdata[i*DATA_W +: DATA_W] =
            (state == S_BUSY && grant == IDX_W'(i)) ? ret_data : '0;
    end

    assign s_bus.valid = s_valid;
    assign s_bus.addr  = addr_a[grant];
    assign s_bus.wdata = wdata_a[grant];
    assign s_bus.wstrb = wstrb_a[grant];

    // Scan last+1, last+2, ... so the previous winner has lowest priority.
    always_comb begin
        pick    = last;
        cand    = last;
        any_req = 1'b0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = IDX_W'((int'(last) + k) % N_MASTERS);
            if (!any_req && m_bus.valid[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        last_n    = last;
        wd_n      = wd_cnt;
        terr_n    = timeout_err;
        emst_n    = err_master;
        s_valid   = 1'b0;
        ret_ready = 1'b0;
        ret_data  = s_bus.rdata;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    grant_n = pick;
                    last_n  = pick;
                    wd_n    = '0;
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                s_valid = m_bus.valid[grant];
                if (!m_bus.valid[grant]) begin
                    state_n = S_IDLE;
                end else if (s_bus.ready[0]) begin
                    ret_ready = 1'b1;
                    state_n   = S_IDLE;
                end else if (WD_EN && wd_cnt == WD_LAST) begin
                    // Abort: complete the master with zero data and withdraw from the slave.
                    s_valid   = 1'b0;
                    ret_ready = 1'b1;
                    ret_data  = '0;
                    terr_n    = 1'b1;
                    emst_n    = 3'(grant);
                    state_n   = S_IDLE;
                end else if (WD_EN) begin
                    wd_n = wd_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            grant       <= '0;
            last        <= IDX_W'(N_MASTERS - 1);
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            err_master  <= 3'd0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            last        <= last_n;
            wd_cnt      <= wd_n;
            timeout_err <= terr_n;
            err_master  <= emst_n;
        end
    end
endmodule

// File: doc/native_arbiter.md
# native_arbiter

Round-robin arbiter that shares one native-bus slave (for example the external-memory/DDR interface or the UART) between N native-bus masters such as the CPU instruction port, CPU data port and a boot/DMA loader. It sits between the masters and the slave inside `system`. It serialises transactions with one outstanding access at a time. A watchdog completes any access the slave never acknowledges, so a dead slave cannot hang the masters.

## Interface
Parameters:
- `N_MASTERS`, 2: number of requesters, 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; strobe width is `DATA_W/8`.
- `TIMEOUT`, 1024: cycles in BUSY before abort; 0 disables the watchdog.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `m_valid`  in  N_MASTERS: per-master request.
- `m_addr`  in  N_MASTERS*ADDR_W: flattened; master i uses slice i.
- `m_wdata`  in  N_MASTERS*DATA_W: flattened write data.
- `m_wstrb`  in  N_MASTERS*DATA_W/8: flattened byte strobes; all zero means read.
- `m_rdata`  out  N_MASTERS*DATA_W: flattened read data.
- `m_ready`  out  N_MASTERS: one-cycle completion pulse per master.
- `s_valid`  out  1: request to the slave.
- `s_addr`  out  ADDR_W: address to the slave.
- `s_wdata`  out  DATA_W: write data to the slave.
- `s_wstrb`  out  DATA_W/8: byte strobes to the slave.
- `s_rdata`  in  DATA_W: read data from the slave.
- `s_ready`  in  1: slave completion pulse.
- `timeout_err`  out  1: sticky flag, set on the first watchdog abort.
- `err_master`  out  3: index of the master that owned the most recent aborted access.

## Operation
- States: IDLE and BUSY. Registers: `grant` (index), `last` (index of the previous winner), watchdog counter `wd_cnt`.
- IDLE:
  - If any `m_valid` bit is set, select the first requesting index scanning `last+1, last+2, …` modulo N_MASTERS.
  - Register it into `grant` and `last`, clear `wd_cnt`, and go to BUSY.
  - No slave request is issued in IDLE.
- BUSY, slave-side forwarding:
  - `s_valid = m_valid[grant]`.
  - `s_addr`, `s_wdata` and `s_wstrb` are driven combinationally from slice `grant`.
- BUSY, master-side return:
  - `m_ready[grant] = s_ready`.
  - `m_rdata` slice `grant` = `s_rdata`.
  - All other `m_ready` bits are 0, and all other `m_rdata` slices are 0.
- BUSY exits:
  - On `s_ready`, go to IDLE.
  - If the granted master drops `m_valid` before `s_ready` (protocol violation), go to IDLE and issue no `m_ready`.
  - Watchdog (TIMEOUT>0): `wd_cnt` increments each BUSY cycle without `s_ready`. When `wd_cnt == TIMEOUT-1` and `s_ready` is still low:
    - force `m_ready[grant]=1` with `m_rdata` slice = 0;
    - set `timeout_err`; load `err_master=grant`;
    - go to IDLE.
    - `s_valid` is 0 in that cycle. A later stray `s_ready` while IDLE is ignored.
- The grant is never changed mid-transaction. Strobe and data are passed through unmodified.
- `timeout_err` is cleared only by reset.

## Timing
- Reset values:
  - state=IDLE, `grant`=0, `last`=N_MASTERS-1 (so master 0 wins first);
  - `wd_cnt`=0, `timeout_err`=0, `err_master`=0;
  - `s_valid`=0, `m_ready`=0, all `m_rdata`=0.
- Arbitration latency: `m_valid` high in cycle t (IDLE) → `s_valid` high in cycle t+1.
- Zero-wait slave: `s_ready` in t+1 → `m_ready` in t+1 (combinational), IDLE in t+2, next grant takes effect in t+3. Minimum 2 cycles per transaction.
- A master that holds `m_valid` high after its `m_ready` is treated as a new request and re-arbitrated against the others.
- Simultaneous `s_ready` and watchdog expiry: `s_ready` wins. The real `s_rdata` is returned and no error is flagged.
- Reset asserted mid-BUSY: immediate return to reset values. The slave sees `s_valid` drop asynchronously.
- No combinational path from `m_valid` to `grant`. The only combinational paths are forwarding through the registered `grant`.

## Test plan
- Single master: master 0 reads 0x100, slave answers 0xCAFEF00D after 3 wait cycles → `s_valid` 1 cycle after request, `m_ready[0]` pulses once with 0xCAFEF00D, `m_ready[1]`=0.
- Contention: masters 0 and 1 both request continuously for 6 transactions, zero-wait slave → grants alternate 0,1,0,1,0,1, each master gets exactly 3 `m_ready`, 2 cycles per transaction.
- Rotation with N_MASTERS=3: after master 2 is served and masters 0 and 1 both request → master 0 is granted next, then master 1.
- Write: master 1 writes 0x12345678 with wstrb 0b0011 to 0x40 → slave sees exactly that addr, data and strobe; `m_rdata` slice 1 = `s_rdata` during `m_ready`.
- Watchdog with TIMEOUT=8: slave never answers master 1 → `m_ready[1]` at the 8th BUSY cycle with data 0, `timeout_err`=1, `err_master`=1. A following master 0 access completes normally and `timeout_err` stays 1.
- Reset mid-transaction: assert `reset` during BUSY → `s_valid`=0 immediately; after release, master 0 wins first even if master 1 also requests.
